// File: rtl/score_pkg.sv
// Shared types and helpers for the score/high-score display controller.
package score_pkg;

    // One BCD digit; always held in 0..9.
    typedef logic [3:0] bcd_t;

    // Four packed BCD digits, [3] = thousands ... [0] = ones.
    typedef bcd_t [3:0] bcd4_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } game_state_t;

    // Saturation point of the score counter.
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Leading-zero suppression flags for a four-digit value.
    // The ones digit is never blanked, so an all-zero value still shows "0".
    function automatic logic [3:0] lead_blank(input bcd4_t v);
        logic [3:0] b;
        b[3] = (v[3] == 4'd0);
        b[2] = b[3] && (v[2] == 4'd0);
        b[1] = b[2] && (v[1] == 4'd0);
        b[0] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/score_display_ctrl_bcd_digit.sv
// Single decade of the BCD score counter. Chained through carry to form
// the four-digit score; the clear input has priority over increment.
module bcd_digit
    import score_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    bcd_t q_q;
    bcd_t q_d;

    // Ripple into the next decade when this one rolls 9 -> 0.
    assign carry = inc && (q_q == 4'd9);

    // Next digit value: clear, roll over, or step by one.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = carry ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Game-side controller for the 4-digit seven-segment display: keeps the
// BCD score and session high score, chooses what is shown per game phase,
// alternates score/high after a crash, and flags leading zeros for blanking.
// Display registers are loaded from next-state values so dig*/blank move
// on the same edge as state.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int BLINK_CYCLES = 25_000_000
)
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       point,
    input  logic       crash,
    input  logic       clear_high,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] blank,
    output logic [1:0] state,
    output logic       new_high
);

    localparam int              CW       = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(BLINK_CYCLES - 1);

    game_state_t   state_q, state_d;

    // Score counter chain
    bcd_t          digit_q [4];
    logic          carry_c [4];
    logic          inc_c   [4];
    bcd4_t         score_q;
    bcd4_t         score_nxt;
    logic          score_clr;
    logic          point_ok;

    // Session state
    bcd4_t         high_q, high_d;
    logic          new_high_q, new_high_d;
    logic [CW-1:0] blink_q, blink_d;
    logic          show_high_q, show_high_d;

    // Registered display
    bcd4_t         disp_d, dig_q;
    logic [3:0]    blank_d, blank_q;

    // A new game clears the score; points only count while playing and
    // below the 9999 ceiling, so the chain never wraps.
    assign score_clr = start && ((state_q == IDLE) || (state_q == OVER));
    assign point_ok  = (state_q == PLAY) && point && (score_q != BCD_MAX);

    // Ripple-carry increment chain feeding the digit counters.
    always_comb begin
        inc_c[0] = point_ok;
        for (int i = 1; i < 4; i++) begin
            inc_c[i] = carry_c[i-1];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit u_digit (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (score_clr),
            .inc     (inc_c[g]),
            .q       (digit_q[g]),
            .carry   (carry_c[g])
        );
    end

    // Current score and its post-edge value (used for crash compare and display).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            score_q[i] = digit_q[i];
            if (score_clr) begin
                score_nxt[i] = '0;
            end else if (!inc_c[i]) begin
                score_nxt[i] = digit_q[i];
            end else if (carry_c[i]) begin
                score_nxt[i] = '0;
            end else begin
                score_nxt[i] = digit_q[i] + 4'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start begins a game, crash ends it; 2'b11 recovers to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PLAY;
            PLAY:    if (crash) state_d = OVER;
            OVER:    if (start) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    // Session next-state: high-score update on crash, clear in IDLE, and the
    // game-over alternation timer (held at zero outside OVER so entry starts fresh).
    always_comb begin
        high_d      = high_q;
        new_high_d  = new_high_q;
        blink_d     = '0;
        show_high_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_high) high_d = '0;
            end
            PLAY: begin
                if (crash) begin
                    // BCD ordering equals numeric ordering, so a plain compare works.
                    if (score_nxt > high_q) begin
                        high_d     = score_nxt;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    new_high_d = 1'b0;
                end else if (blink_q == CNT_LAST) begin
                    show_high_d = ~show_high_q;
                end else begin
                    blink_d     = blink_q + CW'(1);
                    show_high_d = show_high_q;
                end
            end
            default: ;
        endcase
    end

    // FSM output: select the value to show after this edge and its blank flags.
    always_comb begin
        case (state_d)
            PLAY:    disp_d = score_nxt;
            OVER:    disp_d = show_high_d ? high_d : score_nxt;
            default: disp_d = high_d;
        endcase
        blank_d = lead_blank(disp_d);
    end

    // Session and display registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_q      <= '0;
            new_high_q  <= 1'b0;
            blink_q     <= '0;
            show_high_q <= 1'b0;
            dig_q       <= '0;
            blank_q     <= 4'b1110;
        end else begin
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            blink_q     <= blink_d;
            show_high_q <= show_high_d;
            dig_q       <= disp_d;
            blank_q     <= blank_d;
        end
    end

    assign dig0     = dig_q[0];
    assign dig1     = dig_q[1];
    assign dig2     = dig_q[2];
    assign dig3     = dig_q[3];
    assign blank    = blank_q;
    assign state    = state_q;
    assign new_high = new_high_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed game scenarios followed by random
// pulse traffic, each cycle compared against an integer-valued game model.
module tb_score_display_ctrl;

    localparam int BLINK = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0, point = 1'b0, crash = 1'b0, clear_high = 1'b0;
    logic [3:0] dig0, dig1, dig2, dig3, blank;
    logic [1:0] state;
    logic       new_high;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integers, 0=IDLE 1=PLAY 2=OVER
    int m_state, m_score, m_high, m_tick;
    bit m_show, m_nh;

    score_display_ctrl #(.BLINK_CYCLES(BLINK)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .point      (point),
        .crash      (crash),
        .clear_high (clear_high),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .blank      (blank),
        .state      (state),
        .new_high   (new_high)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_tick = 0; m_show = 0; m_nh = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit ch);
        case (m_state)
            0: begin
                if (ch) m_high = 0;
                if (s) begin m_state = 1; m_score = 0; end
            end
            1: begin
                if (p && m_score < 9999) m_score++;
                if (c) begin
                    m_state = 2;
                    m_nh    = (m_score > m_high);
                    if (m_nh) m_high = m_score;
                    m_tick  = 0;
                    m_show  = 0;
                end
            end
            default: begin
                if (s) begin
                    m_state = 1; m_score = 0; m_nh = 0;
                end else begin
                    m_tick++;
                    if (m_tick == BLINK) begin m_tick = 0; m_show = !m_show; end
                end
            end
        endcase
    endtask

    function automatic int exp_val();
        if (m_state == 0) return m_high;
        if (m_state == 1) return m_score;
        return m_show ? m_high : m_score;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] digs();
        return {dig3, dig2, dig1, dig0};
    endfunction

    task automatic chk_all(input string tag);
        int v;
        logic [3:0] b;
        v = exp_val();
        b = {v < 1000, v < 100, v < 10, 1'b0};
        chk({tag, "/dig"},   digs(), to_bcd(v));
        chk({tag, "/blank"}, {12'd0, blank}, {12'd0, b});
        chk({tag, "/state"}, {14'd0, state}, 16'(m_state));
        chk({tag, "/nhigh"}, {15'd0, new_high}, {15'd0, m_nh});
    endtask

    // Called at a negedge: drive one cycle of pulses, then check at next negedge.
    task automatic tick(input bit s, input bit p, input bit c, input bit ch);
        start = s; point = p; crash = c; clear_high = ch;
        @(posedge clock);
        model_step(s, p, c, ch);
        @(negedge clock);
        start = 0; point = 0; crash = 0; clear_high = 0;
        chk_all("cyc");
    endtask

    // Assert reset between edges and check outputs before the next posedge.
    task automatic async_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("arst");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk_all("reset");
        chk("reset_blank", {12'd0, blank}, 16'h000E);
        reset_n = 1'b1;

        // IDLE ignores points
        repeat (3) tick(0, 1, 0, 0);
        chk("idle_pts", digs(), 16'h0000);

        // Counting and carry through 0099 -> 0100
        tick(1, 0, 0, 0);
        repeat (12) tick(0, 1, 0, 0);
        chk("s12", digs(), 16'h0012);
        chk("s12_blank", {12'd0, blank}, 16'h000C);
        chk("s12_state", {14'd0, state}, 16'd1);
        repeat (87) tick(0, 1, 0, 0);
        chk("s99", digs(), 16'h0099);
        tick(0, 1, 0, 0);
        chk("s100", digs(), 16'h0100);
        chk("s100_blank", {12'd0, blank}, 16'h0008);

        // Climb to 9998 then saturate at 9999
        while (m_score < 9998) tick(0, 1, 0, 0);
        chk("s9998", digs(), 16'h9998);
        repeat (3) tick(0, 1, 0, 0);
        chk("s9999", digs(), 16'h9999);
        chk("s9999_blank", {12'd0, blank}, 16'h0000);

        // Game A: 5 points, new high
        async_reset();
        tick(1, 0, 0, 0);
        repeat (5) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        chk("gA_state", {14'd0, state}, 16'd2);
        chk("gA_nh", {15'd0, new_high}, 16'd1);
        chk("gA_dig", digs(), 16'h0005);
        repeat (12) tick(0, 0, 0, 0);

        // Game B: 3 points, no new high; alternation 0003/0005, 4 cycles each
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        chk("gB_nh", {15'd0, new_high}, 16'd0);
        chk("gB_dig0", digs(), 16'h0003);
        for (int k = 1; k <= 12; k++) begin
            tick(0, 0, 0, (k == 5));
            chk("gB_alt", digs(), ((k / 4) % 2) ? 16'h0005 : 16'h0003);
        end

        // Point and crash together at 0007
        tick(1, 0, 0, 0);
        repeat (7) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        chk("pc_nh", {15'd0, new_high}, 16'd1);
        chk("pc_score", digs(), 16'h0008);
        repeat (4) tick(0, 0, 0, 0);
        chk("pc_high", digs(), 16'h0008);

        // Mid-PLAY async reset
        tick(1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0);
        async_reset();
        chk("mid_rst_state", {14'd0, state}, 16'd0);
        chk("mid_rst_dig", digs(), 16'h0000);

        // clear_high in IDLE, then ignored in PLAY
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        repeat (6) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        repeat (2) tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        chk("clr_play_nh", {15'd0, new_high}, 16'd0);
        repeat (4) tick(0, 0, 0, 0);
        chk("clr_play_high", digs(), 16'h0006);

        // start and clear_high together in IDLE
        async_reset();
        tick(1, 0, 0, 1);
        chk("start_clr_state", {14'd0, state}, 16'd1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                tick($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Game-side controller that owns the four BCD digits driven into the 4-digit seven-segment decoder of the flappy_bird top level.
- Counts the current score in BCD and holds the session high score.
- Sequences what the display shows: high score when idle, live score while playing, and an alternating score/high-score view after a crash.
- Produces per-digit blank flags for leading-zero suppression; the top level forces blanked digits' segments to 7'b1111111.

Parameters:
- BLINK_CYCLES, 25_000_000, clock cycles per half-period of the game-over alternation (0.5 s at 50 MHz); must be >= 2.

Ports:
- clock  in  1  system clock (CLOCK_50 at top).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin a new game.
- point  in  1  one-cycle pulse; bird passed a pipe.
- crash  in  1  one-cycle pulse; collision, game ends.
- clear_high  in  1  one-cycle pulse; zero the high score.
- dig0  out  4  displayed ones digit, BCD.
- dig1  out  4  displayed tens digit.
- dig2  out  4  displayed hundreds digit.
- dig3  out  4  displayed thousands digit.
- blank  out  4  blank[i]=1 suppresses digit i.
- state  out  2  00 IDLE, 01 PLAY, 10 OVER.
- new_high  out  1  last finished game set a new high score.

Behaviour:

Clocking, reset and latency:
- Single clock domain; all state updates on posedge clock.
- reset_n low asynchronously forces: state=IDLE, score=0000, high=0000, blink counter=0, show_high=0, new_high=0, dig0..dig3=0, blank=4'b1110.
- Outputs are registered: a change on an input edge is visible on dig*/blank/state one cycle later.

States:
- IDLE:
  - Display shows the high score.
  - start -> PLAY; score cleared to 0000 on the same edge.
  - clear_high -> high=0000.
  - point and crash are ignored.
  - If start and clear_high arrive together, both take effect.
- PLAY:
  - Display shows the live score.
  - point increments the score by 1 in BCD with ripple carry (9->0 carries into the next digit).
  - The score saturates at 9999; further points are ignored.
  - crash -> OVER. On that edge, if the post-increment score is greater than high, then high<=score and new_high<=1; otherwise new_high<=0.
  - If point and crash arrive in the same cycle, the point is counted first and the comparison uses the incremented value.
  - start and clear_high are ignored.
- OVER:
  - Blink counter counts 0..BLINK_CYCLES-1 and wraps.
  - show_high toggles on each wrap; display shows score when show_high=0 and high when show_high=1.
  - Entry into OVER resets the blink counter to 0 and show_high to 0.
  - start -> PLAY: score=0000, new_high=0, blink counter and show_high cleared.
  - point, crash and clear_high are ignored.
- Illegal state encoding 11 -> IDLE on the next edge.

Blanking:
- Computed from the value being displayed.
- blank[3]=1 if dig3==0.
- blank[2]=1 if dig3==0 and dig2==0.
- blank[1]=1 if dig3, dig2 and dig1 are all 0.
- blank[0] is always 0.

Arithmetic:
- Each BCD digit is held in 0..9 at all times; a digit never takes the codes 10..15.
- The score/high comparison is a plain 16-bit unsigned compare of the packed BCD {d3,d2,d1,d0}; this is valid because BCD ordering matches numeric ordering.

Reset mid-operation:
- Reset in any state returns to IDLE with the high score lost; there is no persistence across reset.

Decomposition:
- Package score_pkg:
  - typedef bcd_t = logic [3:0].
  - typedef bcd4_t = bcd_t [3:0].
  - enum game_state_t {IDLE=2'b00, PLAY=2'b01, OVER=2'b10}.
  - constant BCD_MAX = 16'h9999.
- Sub-module bcd_digit:
  - Inputs: clock, reset_n, clr, inc.
  - Outputs: q[3:0], carry (asserted when q==9 and inc).
  - Instantiated four times in a carry chain; the saturation check at 9999 gates the chain's inc input.
- Display mux, blanking and blink counter stay in the top module.

Test Plan (bench uses BLINK_CYCLES=4):
- Reset then idle: dig*=0, blank=1110, state=00, new_high=0; pulse point 3x in IDLE -> display stays 0000.
- start then 12 point pulses: state=01, dig1=1, dig0=2, blank=1100; further point pulses carry correctly through 0099 -> 0100 (blank=1000).
- Preload score to 9998, then 3 point pulses: score = 9999 and holds, blank=0000; no wrap to 0000.
- Game A scores 5 then crash -> state=10, high=0005, new_high=1. Display then alternates 0005/0005 every 4 cycles. Game B scores 3 then crash -> new_high=0, high stays 0005, display alternates 0003/0005 with each value held exactly 4 cycles.
- point and crash in the same cycle at score 0007: high=0008, new_high=1.
- Mid-PLAY reset_n pulse asserted between clock edges: outputs go to their reset values immediately (before the next edge), state=00. Afterwards clear_high in IDLE zeros a nonzero high; clear_high in PLAY has no effect.
